// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: pipeline register indices,
// stall/flush patterns, FSM state and the per-cycle hazard selection.
package hazard_ctrl_pkg;

    // Bit index of each pipeline register in stall/flush vectors (STG_WB is MEM/WB).
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_WB  = 4;
    localparam int NUM_STG = STG_WB + 1;

    typedef logic [NUM_STG-1:0] stage_vec_t;

    localparam stage_vec_t STALL_MEM = stage_vec_t'((1 << STG_PC) | (1 << STG_IF) | (1 << STG_ID) | (1 << STG_EX));
    localparam stage_vec_t FLUSH_MEM = stage_vec_t'(1 << STG_WB);
    localparam stage_vec_t STALL_EX  = stage_vec_t'((1 << STG_PC) | (1 << STG_IF) | (1 << STG_ID));
    localparam stage_vec_t FLUSH_EX  = stage_vec_t'(1 << STG_EX);
    localparam stage_vec_t FLUSH_BR  = stage_vec_t'((1 << STG_IF) | (1 << STG_ID));
    localparam stage_vec_t STALL_LU  = stage_vec_t'((1 << STG_PC) | (1 << STG_IF));
    localparam stage_vec_t FLUSH_LU  = stage_vec_t'(1 << STG_ID);
    localparam stage_vec_t FLUSH_ALL = '1;

    typedef enum logic {
        ST_RUN,
        ST_EX_WAIT
    } hz_state_t;

    // Which hazard wins this cycle, in priority order.
    typedef enum logic [2:0] {
        HZ_RESET,
        HZ_MEM,
        HZ_EX_HOLD,
        HZ_EX_DONE,
        HZ_BRANCH,
        HZ_LOAD_USE,
        HZ_NONE
    } hz_sel_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Bank of three wrap-around event counters for hazard statistics.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_en,
    input  logic             redirect_en,
    input  logic             load_use_en,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] load_use_cnt
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            redirect_cnt <= '0;
            load_use_cnt <= '0;
        end else begin
            if (stall_en)    stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect_en) redirect_cnt <= redirect_cnt + CNT_W'(1);
            if (load_use_en) load_use_cnt <= load_use_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle EX, memory wait and
// branch redirect handling with a multi-cycle watchdog and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_EX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs1_re_id_i,
    input  logic        rs2_re_id_i,
    input  logic [4:0]  rs1_addr_id_i,
    input  logic [4:0]  rs2_addr_id_i,
    input  logic        ex_is_load_i,
    input  logic        rd_we_ex_i,
    input  logic [4:0]  rd_addr_ex_i,
    input  logic        ex_start_i,
    input  logic        ex_done_i,
    input  logic        branch_taken_ex_i,
    input  logic [31:0] branch_target_ex_i,
    input  logic        mem_stall_i,
    output logic [4:0]  stall_o,
    output logic [4:0]  flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        ex_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] load_use_cnt_o
);

    localparam int WAIT_W = $clog2(MAX_EX_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_EX_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_EX_CYCLES - 1);

    hz_state_t         state_q, state_d;
    hz_sel_t           hz_sel;
    logic              load_use, ex_hold, wait_tick;
    logic [WAIT_W-1:0] wait_cnt_q;

    assign load_use = ex_is_load_i & rd_we_ex_i & (rd_addr_ex_i != 5'd0) &
                      ((rs1_re_id_i & (rs1_addr_id_i == rd_addr_ex_i)) |
                       (rs2_re_id_i & (rs2_addr_id_i == rd_addr_ex_i)));

    assign ex_hold = ((state_q == ST_EX_WAIT) | ((state_q == ST_RUN) & ex_start_i)) & ~ex_done_i;

    always_comb begin
        if (rst)                                         hz_sel = HZ_RESET;
        else if (mem_stall_i)                            hz_sel = HZ_MEM;
        else if (ex_hold)                                hz_sel = HZ_EX_HOLD;
        else if (state_q == ST_EX_WAIT)                  hz_sel = HZ_EX_DONE;
        else if (branch_taken_ex_i)                      hz_sel = HZ_BRANCH;
        else if (load_use)                               hz_sel = HZ_LOAD_USE;
        else                                             hz_sel = HZ_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (hz_sel)
            HZ_EX_HOLD: if (state_q == ST_RUN) state_d = ST_EX_WAIT;
            HZ_EX_DONE: state_d = ST_RUN;
            default:    state_d = state_q;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would infer a latch.
    always_comb begin
        stall_o       = '0;
        flush_o       = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (hz_sel)
            HZ_RESET:    flush_o = FLUSH_ALL;
            HZ_MEM:      begin stall_o = STALL_MEM; flush_o = FLUSH_MEM; end
            HZ_EX_HOLD:  begin stall_o = STALL_EX;  flush_o = FLUSH_EX;  end
            HZ_BRANCH:   begin
                flush_o       = FLUSH_BR;
                redirect_o    = 1'b1;
                redirect_pc_o = branch_target_ex_i;
            end
            HZ_LOAD_USE: begin stall_o = STALL_LU;  flush_o = FLUSH_LU;  end
            default:     ;
        endcase
    end

    // Watchdog is diagnostic only: the counter saturates and the flag is sticky.
    assign wait_tick = (state_q == ST_EX_WAIT) & ~mem_stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q   <= '0;
            ex_timeout_o <= 1'b0;
        end else begin
            if (state_q == ST_RUN && state_d == ST_EX_WAIT)
                wait_cnt_q <= '0;
            else if (wait_tick && wait_cnt_q != WAIT_MAX)
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            if (wait_tick && wait_cnt_q == WAIT_LAST)
                ex_timeout_o <= 1'b1;
        end
    end

    hazard_perf_cnt #(.CNT_W(32)) u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_en     (stall_o[STG_PC]),
        .redirect_en  (redirect_o),
        .load_use_en  (hz_sel == HZ_LOAD_USE),
        .stall_cycles (stall_cycles_o),
        .redirect_cnt (redirect_cnt_o),
        .load_use_cnt (load_use_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, multi-cycle sequences,
// and a narrow perf-counter instance for wrap-around.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rs1_re, rs2_re, is_load, rd_we, ex_start, ex_done, br, mem_stall;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] target;
    logic [4:0]  stall_o, flush_o;
    logic        redirect_o, ex_timeout_o;
    logic [31:0] redirect_pc_o, stall_cycles_o, redirect_cnt_o, load_use_cnt_o;

    logic        w_rst, w_stall_en, w_redir_en, w_lu_en;
    logic [3:0]  w_stall, w_redir, w_lu;

    int errors = 0;
    int checks = 0;
    int m_stall = 0, m_redir = 0, m_lu = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_EX_CYCLES(8)) dut (
        .clk (clk), .rst (rst),
        .rs1_re_id_i (rs1_re), .rs2_re_id_i (rs2_re),
        .rs1_addr_id_i (rs1), .rs2_addr_id_i (rs2),
        .ex_is_load_i (is_load), .rd_we_ex_i (rd_we), .rd_addr_ex_i (rd),
        .ex_start_i (ex_start), .ex_done_i (ex_done),
        .branch_taken_ex_i (br), .branch_target_ex_i (target),
        .mem_stall_i (mem_stall),
        .stall_o (stall_o), .flush_o (flush_o),
        .redirect_o (redirect_o), .redirect_pc_o (redirect_pc_o),
        .ex_timeout_o (ex_timeout_o),
        .stall_cycles_o (stall_cycles_o), .redirect_cnt_o (redirect_cnt_o),
        .load_use_cnt_o (load_use_cnt_o)
    );

    hazard_perf_cnt #(.CNT_W(4)) u_wrap (
        .clk (clk), .rst (w_rst),
        .stall_en (w_stall_en), .redirect_en (w_redir_en), .load_use_en (w_lu_en),
        .stall_cycles (w_stall), .redirect_cnt (w_redir), .load_use_cnt (w_lu)
    );

    typedef struct {
        logic rs1_re; logic [4:0] rs1; logic rs2_re; logic [4:0] rs2;
        logic ld; logic we; logic [4:0] rd;
        logic st; logic dn; logic br; logic [31:0] tgt; logic ms;
        logic [4:0] es; logic [4:0] ef; logic er; logic [31:0] ep;
    } vec_t;

    typedef struct {
        string name; logic [4:0] stall; logic [4:0] flush; logic red; logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rs1_re_a, input logic [4:0] rs1_a,
                               input logic rs2_re_a, input logic [4:0] rs2_a,
                               input logic ld, input logic we, input logic [4:0] rd_a,
                               input logic st, input logic dn, input logic br_a,
                               input logic [31:0] tgt, input logic ms,
                               input logic [4:0] es, input logic [4:0] ef,
                               input logic er, input logic [31:0] ep);
        vec_t t;
        t.rs1_re = rs1_re_a; t.rs1 = rs1_a; t.rs2_re = rs2_re_a; t.rs2 = rs2_a;
        t.ld = ld; t.we = we; t.rd = rd_a; t.st = st; t.dn = dn; t.br = br_a;
        t.tgt = tgt; t.ms = ms; t.es = es; t.ef = ef; t.er = er; t.ep = ep;
        return t;
    endfunction

    // Control-only vector: no register operands, no redirect expected.
    function automatic vec_t ctl(input logic st, input logic dn, input logic br_a,
                                 input logic ms, input logic [4:0] es, input logic [4:0] ef);
        return v(0, 0, 0, 0, 0, 0, 0, st, dn, br_a, 32'h0000_0200, ms, es, ef, 0, 0);
    endfunction

    // Drive one cycle at posedge+1, queue its expectation, advance the counter model.
    task automatic step(input vec_t t, input string name);
        exp_t e;
        rs1_re = t.rs1_re; rs1 = t.rs1; rs2_re = t.rs2_re; rs2 = t.rs2;
        is_load = t.ld; rd_we = t.we; rd = t.rd;
        ex_start = t.st; ex_done = t.dn; br = t.br; target = t.tgt; mem_stall = t.ms;
        e.name = name; e.stall = t.es; e.flush = t.ef; e.red = t.er; e.pc = t.ep;
        exp_q.push_back(e);
        if (rst) begin
            m_stall = 0; m_redir = 0; m_lu = 0;
        end else begin
            if (t.es[0]) m_stall++;
            if (t.er) m_redir++;
            if (t.es == 5'b00011 && t.ef == 5'b00100) m_lu++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name);
        check({name, ".stall_cycles"}, stall_cycles_o, m_stall);
        check({name, ".redirect_cnt"}, redirect_cnt_o, m_redir);
        check({name, ".load_use_cnt"}, load_use_cnt_o, m_lu);
    endtask

    // Scoreboard: compare combinational outputs mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".stall"}, 32'(stall_o), 32'(e.stall));
            check({e.name, ".flush"}, 32'(flush_o), 32'(e.flush));
            check({e.name, ".redirect"}, 32'(redirect_o), 32'(e.red));
            check({e.name, ".redirect_pc"}, redirect_pc_o, e.pc);
        end
    end

    localparam int NV = 14;
    vec_t  tbl[NV];
    string tname[NV];

    initial begin
        tbl[0]  = v(0,0,1,5,1,1,5, 0,0,0,0,0, 5'b00011,5'b00100,0,0);           tname[0]  = "lu_rs2";
        tbl[1]  = v(0,0,1,0,1,1,0, 0,0,0,0,0, 5'b00000,5'b00000,0,0);           tname[1]  = "lu_rd0";
        tbl[2]  = v(1,7,0,0,1,1,7, 0,0,0,0,0, 5'b00011,5'b00100,0,0);           tname[2]  = "lu_rs1";
        tbl[3]  = v(0,7,0,0,1,1,7, 0,0,0,0,0, 5'b00000,5'b00000,0,0);           tname[3]  = "lu_no_re";
        tbl[4]  = v(1,7,0,0,0,1,7, 0,0,0,0,0, 5'b00000,5'b00000,0,0);           tname[4]  = "lu_not_load";
        tbl[5]  = v(1,7,0,0,1,0,7, 0,0,0,0,0, 5'b00000,5'b00000,0,0);           tname[5]  = "lu_no_we";
        tbl[6]  = v(1,3,1,4,1,1,9, 0,0,0,0,0, 5'b00000,5'b00000,0,0);           tname[6]  = "lu_diff";
        tbl[7]  = v(0,0,0,0,0,0,0, 0,0,1,32'h100,0, 5'b00000,5'b00110,1,32'h100); tname[7]  = "branch";
        tbl[8]  = v(0,0,0,0,0,0,0, 0,0,1,32'h100,1, 5'b01111,5'b10000,0,0);      tname[8]  = "branch_mstall";
        tbl[9]  = v(0,0,0,0,0,0,0, 1,1,0,0,0, 5'b00000,5'b00000,0,0);           tname[9]  = "ex_single";
        tbl[10] = v(0,0,0,0,0,0,0, 0,0,1,32'hDEADBEE0,0, 5'b00000,5'b00110,1,32'hDEADBEE0); tname[10] = "branch_after_single";
        tbl[11] = v(1,6,0,0,1,1,6, 0,0,0,0,1, 5'b01111,5'b10000,0,0);           tname[11] = "lu_mstall";
        tbl[12] = v(1,9,1,9,1,1,9, 0,0,0,0,0, 5'b00011,5'b00100,0,0);           tname[12] = "lu_both";
        tbl[13] = v(0,0,0,0,0,0,0, 0,0,0,0,0, 5'b00000,5'b00000,0,0);           tname[13] = "idle";

        rst = 1'b1; w_rst = 1'b1;
        w_stall_en = 1'b0; w_redir_en = 1'b0; w_lu_en = 1'b0;
        rs1_re = 0; rs2_re = 0; rs1 = 0; rs2 = 0; is_load = 0; rd_we = 0; rd = 0;
        ex_start = 0; ex_done = 0; br = 0; target = 0; mem_stall = 0;
        @(posedge clk);
        #1;

        // Reset: outputs forced even with a branch present.
        step(v(0,0,0,0,0,0,0, 0,0,1,32'h55,0, 5'b00000,5'b11111,0,0), "rst_branch");
        rst = 1'b0;
        w_rst = 1'b0;
        check_cnt("after_reset");
        check("after_reset.timeout", 32'(ex_timeout_o), 0);

        for (int i = 0; i < NV; i++) step(tbl[i], tname[i]);
        check_cnt("after_table");

        // Multi-cycle op: start at cycle 0, done at cycle 4; branch in EX_WAIT ignored.
        step(ctl(1,0,0,0, 5'b00111,5'b01000), "div_c0");
        step(ctl(0,0,0,0, 5'b00111,5'b01000), "div_c1");
        step(ctl(0,0,1,0, 5'b00111,5'b01000), "div_c2_branch");
        step(ctl(0,0,0,0, 5'b00111,5'b01000), "div_c3");
        step(ctl(0,1,0,0, 5'b00000,5'b00000), "div_c4_done");
        step(ctl(0,0,0,0, 5'b00000,5'b00000), "div_idle");
        check_cnt("after_div");
        check("after_div.timeout", 32'(ex_timeout_o), 0);

        // Result arrives under mem stall; accepted once the stall drops.
        step(ctl(1,0,0,0, 5'b00111,5'b01000), "mdone_start");
        step(ctl(0,1,0,1, 5'b01111,5'b10000), "mdone_mstall");
        step(ctl(0,1,0,0, 5'b00000,5'b00000), "mdone_accept");
        step(v(0,0,0,0,0,0,0, 0,0,1,32'h300,0, 5'b00000,5'b00110,1,32'h300), "mdone_run_branch");

        // Branch held off by mem stall, taken once the stall drops.
        step(v(0,0,0,0,0,0,0, 0,0,1,32'h100,1, 5'b01111,5'b10000,0,0), "brms_0");
        step(v(0,0,0,0,0,0,0, 0,0,1,32'h100,1, 5'b01111,5'b10000,0,0), "brms_1");
        step(v(0,0,0,0,0,0,0, 0,0,1,32'h100,0, 5'b00000,5'b00110,1,32'h100), "brms_2");
        check_cnt("after_branch");

        // Watchdog: 8 non-stalled EX_WAIT cycles, with one stalled cycle not counted.
        step(ctl(1,0,0,0, 5'b00111,5'b01000), "wd_start");
        for (int i = 0; i < 4; i++) step(ctl(0,0,0,0, 5'b00111,5'b01000), "wd_wait_a");
        step(ctl(0,0,0,1, 5'b01111,5'b10000), "wd_mstall");
        for (int i = 0; i < 3; i++) step(ctl(0,0,0,0, 5'b00111,5'b01000), "wd_wait_b");
        check("wd_after7.timeout", 32'(ex_timeout_o), 0);
        step(ctl(0,0,0,0, 5'b00111,5'b01000), "wd_wait_8");
        check("wd_after8.timeout", 32'(ex_timeout_o), 1);
        step(ctl(0,1,0,0, 5'b00000,5'b00000), "wd_done");
        step(ctl(0,0,0,0, 5'b00000,5'b00000), "wd_idle");
        check("wd_sticky.timeout", 32'(ex_timeout_o), 1);
        check_cnt("after_wd");

        // Reset in EX_WAIT at wait count 3.
        step(ctl(1,0,0,0, 5'b00111,5'b01000), "rmid_start");
        for (int i = 0; i < 3; i++) step(ctl(0,0,0,0, 5'b00111,5'b01000), "rmid_wait");
        rst = 1'b1;
        step(ctl(0,0,0,0, 5'b00000,5'b11111), "rmid_rst");
        rst = 1'b0;
        check_cnt("rmid_after_rst");
        check("rmid_after_rst.timeout", 32'(ex_timeout_o), 0);
        step(ctl(0,0,0,0, 5'b00000,5'b00000), "rmid_run");

        // Counter wrap on a narrow instance of the same counter bank.
        w_stall_en = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        check("wrap.at_max", 32'(w_stall), 32'hF);
        @(posedge clk);
        #1;
        w_stall_en = 1'b0;
        check("wrap.rolled", 32'(w_stall), 0);
        w_redir_en = 1'b1;
        @(posedge clk);
        #1;
        w_redir_en = 1'b0;
        check("wrap.redirect_cnt", 32'(w_redir), 1);
        check("wrap.load_use_cnt", 32'(w_lu), 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
